// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU control codes,
// legal-code check and the arbiter FSM state type.
package alu_arbiter_pkg;

   localparam logic [3:0] CTL_AND = 4'd0;
   localparam logic [3:0] CTL_OR  = 4'd1;
   localparam logic [3:0] CTL_ADD = 4'd2;
   localparam logic [3:0] CTL_SUB = 4'd6;
   localparam logic [3:0] CTL_SLT = 4'd7;
   localparam logic [3:0] CTL_NOR = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic ctl_legal(input logic [3:0] ctl);
      case (ctl)
         CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-cycle combinational ALU; unknown control codes produce a zero result.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [3:0]   ctl,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] alu_out,
   output logic         zero
);

   always_comb begin
      alu_out = '0;
      case (ctl)
         CTL_AND: alu_out = a & b;
         CTL_OR:  alu_out = a | b;
         CTL_ADD: alu_out = a + b;
         CTL_SUB: alu_out = a - b;
         CTL_SLT: alu_out = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         CTL_NOR: alu_out = ~(a | b);
         default: alu_out = '0;
      endcase
      zero = (alu_out == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation
// in flight at a time, result returned on the owner's response channel.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int W    = 32,
   parameter int CNTW = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [3:0]      req0_ctl_i,
   input  logic [W-1:0]    req0_a_i,
   input  logic [W-1:0]    req0_b_i,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [3:0]      req1_ctl_i,
   input  logic [W-1:0]    req1_a_i,
   input  logic [W-1:0]    req1_b_i,
   output logic            rsp0_valid_o,
   input  logic            rsp0_ready_i,
   output logic [W-1:0]    rsp0_result_o,
   output logic            rsp0_zero_o,
   output logic            rsp0_err_o,
   output logic            rsp1_valid_o,
   input  logic            rsp1_ready_i,
   output logic [W-1:0]    rsp1_result_o,
   output logic            rsp1_zero_o,
   output logic            rsp1_err_o,
   output logic            busy_o,
   output logic [CNTW-1:0] ops_cnt_o,
   output logic [1:0]      state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; the sender holds valid and payload stable until that edge.

   state_e          state, state_nxt;
   logic [3:0]      op_ctl;
   logic [W-1:0]    op_a, op_b;
   logic            owner, prio, grant;
   logic [W-1:0]    res_q;
   logic            res_zero_q, res_err_q;
   logic [CNTW-1:0] ops_cnt;
   logic [W-1:0]    alu_out;
   logic            alu_zero;
   logic            rsp_done;

   alu_arbiter_alu #(.W(W)) u_alu (
      .ctl     (op_ctl),
      .a       (op_a),
      .b       (op_b),
      .alu_out (alu_out),
      .zero    (alu_zero)
   );

   always_comb begin
      state_nxt    = state;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      grant        = 1'b0;
      rsp_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            // prio only matters when both requesters are waiting
            if (req0_valid_i && (!req1_valid_i || !prio)) begin
               req0_ready_o = 1'b1;
               state_nxt    = ST_EXEC;
            end else if (req1_valid_i) begin
               req1_ready_o = 1'b1;
               grant        = 1'b1;
               state_nxt    = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            rsp_done = owner ? rsp1_ready_i : rsp0_ready_i;
            if (rsp_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= ST_IDLE;
         op_ctl     <= '0;
         op_a       <= '0;
         op_b       <= '0;
         owner      <= 1'b0;
         prio       <= 1'b0;
         res_q      <= '0;
         res_zero_q <= 1'b0;
         res_err_q  <= 1'b0;
         ops_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (req0_ready_o || req1_ready_o) begin
            op_ctl <= grant ? req1_ctl_i : req0_ctl_i;
            op_a   <= grant ? req1_a_i   : req0_a_i;
            op_b   <= grant ? req1_b_i   : req0_b_i;
            owner  <= grant;
         end
         if (state == ST_EXEC) begin
            res_q      <= alu_out;
            res_zero_q <= alu_zero;
            res_err_q  <= !ctl_legal(op_ctl);
         end
         if (rsp_done) begin
            ops_cnt <= ops_cnt + 1'b1;
            prio    <= ~owner;
         end
      end
   end

   assign rsp0_valid_o  = (state == ST_RESP) && !owner;
   assign rsp1_valid_o  = (state == ST_RESP) && owner;
   assign rsp0_result_o = res_q;
   assign rsp0_zero_o   = res_zero_q;
   assign rsp0_err_o    = res_err_q;
   assign rsp1_result_o = res_q;
   assign rsp1_zero_o   = res_zero_q;
   assign rsp1_err_o    = res_err_q;
   assign busy_o        = (state != ST_IDLE);
   assign ops_cnt_o     = ops_cnt;
   assign state_o       = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed arbitration/backpressure/reset
// sequences and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

   localparam int W    = 32;
   localparam int CNTW = 4;

   logic            clk, rst_n;
   logic            req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]      req0_ctl, req1_ctl;
   logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
   logic            rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
   logic            rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
   logic [W-1:0]    rsp0_result, rsp1_result;
   logic            busy;
   logic [CNTW-1:0] ops_cnt;
   logic [1:0]      state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic prio_m = 1'b0;
   int   cnt_m  = 0;
   logic [W-1:0] exp_q[$];

   alu_arbiter #(.W(W), .CNTW(CNTW)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_ctl_i(req0_ctl),
      .req0_a_i(req0_a), .req0_b_i(req0_b),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_ctl_i(req1_ctl),
      .req1_a_i(req1_a), .req1_b_i(req1_b),
      .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(rsp0_result),
      .rsp0_zero_o(rsp0_zero), .rsp0_err_o(rsp0_err),
      .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(rsp1_result),
      .rsp1_zero_o(rsp1_zero), .rsp1_err_o(rsp1_err),
      .busy_o(busy), .ops_cnt_o(ops_cnt), .state_o(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // {err, zero, result} from the operation definitions
   function automatic logic [W+1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic e;
      e = 1'b0;
      case (c)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd6:  r = a - b;
         4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
         4'd12: r = ~(a | b);
         default: begin r = 0; e = 1'b1; end
      endcase
      return {e, (r == 0), r};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      prio_m = 1'b0;
      cnt_m = 0;
   endtask

   task automatic set_req(input int p, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      if (p == 0) begin req0_valid = 1; req0_ctl = c; req0_a = a; req0_b = b; end
      else        begin req1_valid = 1; req1_ctl = c; req1_a = a; req1_b = b; end
   endtask

   // Waits for a grant, checks arbitration, latency, result and completion.
   // Entered and left just after a rising edge.
   task automatic serve_one(input int stall, output int g, output logic [W-1:0] r,
                            output logic z, output logic e);
      int waited;
      logic [W+1:0] exp;
      logic [W-1:0] exp_r;
      waited = 0;
      g = 0; r = 0; z = 0; e = 0;
      #1;
      while (!(req0_ready || req1_ready) && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!(req0_ready || req1_ready)) begin
         chk("grant_timeout", 0, 1);
         return;
      end
      g = (req0_valid && req1_valid) ? int'(prio_m) : (req0_valid ? 0 : 1);
      chk("grant_port", {31'd0, req1_ready}, g);
      chk("grant_single", {31'd0, req0_ready & req1_ready}, 0);
      exp = (g == 0) ? ref_alu(req0_ctl, req0_a, req0_b) : ref_alu(req1_ctl, req1_a, req1_b);
      exp_q.push_back(exp[W-1:0]);
      @(posedge clk); #1;
      if (g == 0) req0_valid = 0; else req1_valid = 0;
      chk("exec_busy", {31'd0, busy}, 1);
      chk("exec_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 0);
      @(posedge clk); #1;
      chk("rsp_latency", {31'd0, (g == 0) ? rsp0_valid : rsp1_valid}, 1);
      chk("rsp_other_low", {31'd0, (g == 0) ? rsp1_valid : rsp0_valid}, 0);
      r = (g == 0) ? rsp0_result : rsp1_result;
      z = (g == 0) ? rsp0_zero : rsp1_zero;
      e = (g == 0) ? rsp0_err : rsp1_err;
      exp_r = exp_q.pop_front();
      chk("rsp_result", r, exp_r);
      chk("rsp_zero", {31'd0, z}, {31'd0, exp[W]});
      chk("rsp_err", {31'd0, e}, {31'd0, exp[W+1]});
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", {31'd0, (g == 0) ? rsp0_valid : rsp1_valid}, 1);
         chk("stall_result", (g == 0) ? rsp0_result : rsp1_result, exp_r);
         chk("stall_no_ready", {31'd0, req0_ready | req1_ready}, 0);
      end
      if (g == 0) rsp0_ready = 1; else rsp1_ready = 1;
      @(posedge clk); #1;
      rsp0_ready = 0; rsp1_ready = 0;
      prio_m = (g == 0);
      cnt_m  = (cnt_m + 1) % (1 << CNTW);
      chk("ops_cnt", {28'd0, ops_cnt}, cnt_m);
      chk("rsp_done_low", {31'd0, rsp0_valid | rsp1_valid}, 0);
   endtask

   typedef struct {
      logic [3:0]   ctl;
      logic [W-1:0] a, b, res;
      logic         zero, err;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int g;
      logic [W-1:0] r;
      logic z, e;

      tbl[0] = '{4'd2,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
      tbl[1] = '{4'd6,  32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
      tbl[2] = '{4'd7,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
      tbl[3] = '{4'd7,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
      tbl[4] = '{4'd0,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1'b0, 1'b0};
      tbl[5] = '{4'd1,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0, 1'b0};
      tbl[6] = '{4'd12, 32'hFFFF_0000,  32'h0000_FFFE,  32'h0000_0001,  1'b0, 1'b0};
      tbl[7] = '{4'd2,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0};
      tbl[8] = '{4'd6,  32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
      tbl[9] = '{4'd3,  32'd1,          32'd1,          32'd0,          1'b1, 1'b1};

      req0_ctl = 0; req0_a = 0; req0_b = 0;
      req1_ctl = 0; req1_a = 0; req1_b = 0;
      do_reset();

      // reset state
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_rsp_valid", {31'd0, rsp0_valid | rsp1_valid}, 0);
      chk("rst_ready", {31'd0, req0_ready | req1_ready}, 0);
      chk("rst_result", rsp0_result | rsp1_result, 0);
      chk("rst_flags", {30'd0, rsp0_zero | rsp1_zero, rsp0_err | rsp1_err}, 0);
      chk("rst_cnt", {28'd0, ops_cnt}, 0);

      // single req0 ADD
      set_req(0, 4'd2, 32'd5, 32'd7);
      serve_one(0, g, r, z, e);
      chk("single_port", g, 0);
      chk("single_result", r, 32'd12);
      chk("single_cnt", {28'd0, ops_cnt}, 1);

      // both valid from reset: strict alternation
      do_reset();
      for (int p = 0; p < 4; p++) begin
         set_req(0, 4'd6, 32'd9, 32'd9);
         set_req(1, 4'd7, 32'hFFFF_FFFF, 32'd1);
         serve_one(0, g, r, z, e);
         chk("pair_first_port", g, 0);
         chk("pair_first_result", r, 0);
         chk("pair_first_zero", {31'd0, z}, 1);
         serve_one(0, g, r, z, e);
         chk("pair_second_port", g, 1);
         chk("pair_second_result", r, 1);
      end

      // vector table, alternating requester
      foreach (tbl[i]) begin
         set_req(i % 2, tbl[i].ctl, tbl[i].a, tbl[i].b);
         serve_one(0, g, r, z, e);
         chk("tbl_result", r, tbl[i].res);
         chk("tbl_zero", {31'd0, z}, {31'd0, tbl[i].zero});
         chk("tbl_err", {31'd0, e}, {31'd0, tbl[i].err});
      end

      // backpressure on rsp1 while req0 waits
      do_reset();
      set_req(0, 4'd2, 32'd1, 32'd2);
      set_req(1, 4'd1, 32'h10, 32'h01);
      serve_one(0, g, r, z, e);
      set_req(0, 4'd2, 32'd100, 32'd23);
      serve_one(10, g, r, z, e);
      chk("bp_port", g, 1);
      chk("bp_result", r, 32'h11);
      serve_one(0, g, r, z, e);
      chk("bp_next_port", g, 0);
      chk("bp_next_result", r, 32'd123);

      // illegal code still toggles prio
      set_req(0, 4'd3, 32'd1, 32'd1);
      serve_one(0, g, r, z, e);
      chk("ill_result", r, 0);
      chk("ill_flags", {30'd0, z, e}, 3);
      set_req(0, 4'd2, 32'd1, 32'd1);
      set_req(1, 4'd2, 32'd2, 32'd2);
      serve_one(0, g, r, z, e);
      chk("ill_next_port", g, 1);
      serve_one(0, g, r, z, e);

      // reset during EXEC
      set_req(1, 4'd2, 32'd3, 32'd3);
      serve_one(0, g, r, z, e);
      set_req(1, 4'd2, 32'd40, 32'd2);
      #1;
      @(posedge clk); #1;
      req1_valid = 0;
      chk("pre_rst_busy", {31'd0, busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_rsp_valid", {31'd0, rsp0_valid | rsp1_valid}, 0);
      chk("arst_result", rsp0_result | rsp1_result, 0);
      chk("arst_flags", {30'd0, rsp0_zero | rsp1_zero, rsp0_err | rsp1_err}, 0);
      chk("arst_cnt", {28'd0, ops_cnt}, 0);
      @(posedge clk); #1;
      chk("arst_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 0);
      rst_n = 1'b1;
      prio_m = 1'b0;
      cnt_m = 0;
      @(posedge clk); #1;
      chk("arst_still_idle", {31'd0, busy | rsp0_valid | rsp1_valid}, 0);
      set_req(0, 4'd0, 32'hFF, 32'h0F);
      set_req(1, 4'd1, 32'hF0, 32'h0F);
      serve_one(0, g, r, z, e);
      chk("arst_grant", g, 0);
      serve_one(0, g, r, z, e);

      // random traffic and counter wrap: 17 ops from reset
      do_reset();
      for (int n = 0; n < 17; n++) begin
         int pick;
         pick = $urandom_range(1, 3);
         if (pick[0] && !req0_valid)
            set_req(0, 4'($urandom_range(0, 15)), $urandom, $urandom);
         if (pick[1] && !req1_valid)
            set_req(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
         serve_one($urandom_range(0, 3), g, r, z, e);
      end
      chk("cnt_wrap", {28'd0, ops_cnt}, 1);
      if (req0_valid || req1_valid) serve_one(0, g, r, z, e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
